// File: rtl/hicore_commit_unit.sv
// In-order commit stage: pops the ROB head, writes RF/CSR, turns exc/mret/fence.i/mispredict into flush+redirect.
// Latency: RF/CSR/trap writes in the retire cycle; flush+redirect one cycle after a special retire (after the I-cache ack for fence.i).
// Backpressure: retires only when commit_ready is high; commit_valid drops while a flush or an I-cache invalidate is outstanding.
//
// Ports: commit_* handshake and head fields from the ROB; rf_*/csr_*/trap_* write ports (valid only in the
// retire cycle); flush/redirect_* to the pipeline and front end; icache_inv_req/ack invalidate handshake.
// Optional feature macro HICORE_COMMIT_RETIRE_CNT_EN adds the 64-bit minstret retire counter and its port.
module hicore_commit_unit #(
    parameter int PC_SIZE      = 32,
    parameter int REG_SIZE     = 32,
    parameter int RFIDX_WIDTH  = 5,
    parameter int CSRIDX_WIDTH = 12,
    parameter int WB_SIZE      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    commit_valid,
    input  logic                    commit_ready,
    input  logic                    commit_rd_need,
    input  logic [RFIDX_WIDTH-1:0]  commit_rd_idx,
    input  logic [REG_SIZE-1:0]     commit_rd_data,
    input  logic                    commit_csr_need,
    input  logic [CSRIDX_WIDTH-1:0] commit_csr_idx,
    input  logic [REG_SIZE-1:0]     commit_csr_data,
    input  logic                    commit_fence_i_op,
    input  logic                    commit_mret_op,
    input  logic [PC_SIZE-1:0]      commit_next_pc,
    input  logic [WB_SIZE-1:0]      commit_info,
    output logic                    flush,
    output logic                    redirect_valid,
    output logic [PC_SIZE-1:0]      redirect_pc,
    output logic                    rf_wen,
    output logic [RFIDX_WIDTH-1:0]  rf_waddr,
    output logic [REG_SIZE-1:0]     rf_wdata,
    output logic                    csr_wen,
    output logic [CSRIDX_WIDTH-1:0] csr_waddr,
    output logic [REG_SIZE-1:0]     csr_wdata,
    output logic                    trap_wen,
    output logic [PC_SIZE-1:0]      trap_mepc,
    output logic [3:0]              trap_mcause,
    input  logic [PC_SIZE-1:0]      mtvec,
    input  logic [PC_SIZE-1:0]      mepc,
    output logic                    icache_inv_req,
    input  logic                    icache_inv_ack
`ifdef HICORE_COMMIT_RETIRE_CNT_EN
    ,
    output logic [63:0]             minstret
`endif
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FENCE_WAIT = 2'd1,
        FLUSH      = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PC_SIZE-1:0]   target_q, target_d;
    // commit_valid comes straight from a flop so it is 0 during reset without
    // a combinational path from rst_n; it mirrors (state == RUN) afterwards.
    logic                 cv_q;

    logic                 info_exc;
    logic                 info_mispredict;
    logic [3:0]           info_cause;
    logic                 ret;
    logic                 kill_write;
    logic                 unused_info;

    assign info_exc        = commit_info[0];
    assign info_cause      = commit_info[4:1];
    assign info_mispredict = commit_info[5];
    assign unused_info     = ^commit_info[WB_SIZE-1:6];

    assign commit_valid = cv_q & ~flush;
    assign ret          = commit_valid & commit_ready;

    // Exceptions and mret never update architectural registers; fence.i and
    // mispredicted branches still write their results.
    assign kill_write = info_exc | commit_mret_op;

    // ---------------- side-band writes (combinational, retire cycle only) ----------------
    assign rf_wen    = ret & ~kill_write & commit_rd_need & (commit_rd_idx != '0);
    assign rf_waddr  = rf_wen ? commit_rd_idx  : '0;
    assign rf_wdata  = rf_wen ? commit_rd_data : '0;

    assign csr_wen   = ret & ~kill_write & commit_csr_need;
    assign csr_waddr = csr_wen ? commit_csr_idx  : '0;
    assign csr_wdata = csr_wen ? commit_csr_data : '0;

    // The faulting instruction's PC is recovered from its sequential next PC.
    assign trap_wen    = ret & info_exc;
    assign trap_mepc   = trap_wen ? (commit_next_pc - PC_SIZE'(4)) : '0;
    assign trap_mcause = trap_wen ? info_cause : 4'd0;

    // ---------------- registered-state outputs ----------------
    assign flush          = (state_q == FLUSH);
    assign redirect_valid = flush;
    assign redirect_pc    = flush ? target_q : '0;
    assign icache_inv_req = (state_q == FENCE_WAIT);

    // ---------------- next state ----------------
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        unique case (state_q)
            RUN: begin
                if (ret) begin
                    if (info_exc) begin
                        target_d = mtvec;
                        state_d  = FLUSH;
                    end else if (commit_mret_op) begin
                        target_d = mepc;
                        state_d  = FLUSH;
                    end else if (commit_fence_i_op) begin
                        target_d = commit_next_pc;
                        state_d  = FENCE_WAIT;
                    end else if (info_mispredict) begin
                        target_d = commit_next_pc;
                        state_d  = FLUSH;
                    end
                end
            end
            FENCE_WAIT: begin
                if (icache_inv_ack) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            target_q <= '0;
            cv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cv_q     <= (state_d == RUN);
        end
    end

`ifdef HICORE_COMMIT_RETIRE_CNT_EN
    // Counts retired instructions; trapping instructions do not retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            minstret <= 64'd0;
        end else if (ret && !info_exc) begin
            minstret <= minstret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hicore_commit_unit.sv
// Self-checking bench for hicore_commit_unit: directed test-plan scenarios plus random traffic,
// compared every cycle against a behavioural model of the retire/flush/fence rules.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
module tb_hicore_commit_unit;

    localparam int PC_SIZE = 32;
    localparam int REG_SIZE = 32;
    localparam int RFIDX_WIDTH = 5;
    localparam int CSRIDX_WIDTH = 12;
    localparam int WB_SIZE = 8;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    commit_valid;
    logic                    commit_ready;
    logic                    commit_rd_need;
    logic [RFIDX_WIDTH-1:0]  commit_rd_idx;
    logic [REG_SIZE-1:0]     commit_rd_data;
    logic                    commit_csr_need;
    logic [CSRIDX_WIDTH-1:0] commit_csr_idx;
    logic [REG_SIZE-1:0]     commit_csr_data;
    logic                    commit_fence_i_op;
    logic                    commit_mret_op;
    logic [PC_SIZE-1:0]      commit_next_pc;
    logic [WB_SIZE-1:0]      commit_info;
    logic                    flush;
    logic                    redirect_valid;
    logic [PC_SIZE-1:0]      redirect_pc;
    logic                    rf_wen;
    logic [RFIDX_WIDTH-1:0]  rf_waddr;
    logic [REG_SIZE-1:0]     rf_wdata;
    logic                    csr_wen;
    logic [CSRIDX_WIDTH-1:0] csr_waddr;
    logic [REG_SIZE-1:0]     csr_wdata;
    logic                    trap_wen;
    logic [PC_SIZE-1:0]      trap_mepc;
    logic [3:0]              trap_mcause;
    logic [PC_SIZE-1:0]      mtvec;
    logic [PC_SIZE-1:0]      mepc;
    logic                    icache_inv_req;
    logic                    icache_inv_ack;
`ifdef HICORE_COMMIT_RETIRE_CNT_EN
    logic [63:0]             minstret;
`endif

    hicore_commit_unit #(
        .PC_SIZE(PC_SIZE), .REG_SIZE(REG_SIZE), .RFIDX_WIDTH(RFIDX_WIDTH),
        .CSRIDX_WIDTH(CSRIDX_WIDTH), .WB_SIZE(WB_SIZE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_rd_need(commit_rd_need), .commit_rd_idx(commit_rd_idx), .commit_rd_data(commit_rd_data),
        .commit_csr_need(commit_csr_need), .commit_csr_idx(commit_csr_idx), .commit_csr_data(commit_csr_data),
        .commit_fence_i_op(commit_fence_i_op), .commit_mret_op(commit_mret_op),
        .commit_next_pc(commit_next_pc), .commit_info(commit_info),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .trap_wen(trap_wen), .trap_mepc(trap_mepc), .trap_mcause(trap_mcause),
        .mtvec(mtvec), .mepc(mepc),
        .icache_inv_req(icache_inv_req), .icache_inv_ack(icache_inv_ack)
`ifdef HICORE_COMMIT_RETIRE_CNT_EN
        , .minstret(minstret)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // started   : at least one clock edge seen since reset release
    // wait_ack  : a fence.i retired and the I-cache has not acknowledged yet
    // flush_now : this cycle is the flush/redirect cycle
    bit          m_started, m_wait_ack, m_flush_now;
    logic [31:0] m_target;
    logic [63:0] m_retired;

    always @(negedge clk) begin
        bit exp_cv, exp_ret, writes, exp_rf, exp_csr, exp_trap;
        logic [31:0] exp_mepc;
        if (!rst_n) begin
            check("rst_commit_valid", commit_valid, 0);
            check("rst_flush", flush, 0);
            check("rst_redirect_valid", redirect_valid, 0);
            check("rst_inv_req", icache_inv_req, 0);
            check("rst_rf_wen", rf_wen, 0);
            check("rst_csr_wen", csr_wen, 0);
            check("rst_trap_wen", trap_wen, 0);
            m_started = 0; m_wait_ack = 0; m_flush_now = 0;
            m_target = 0; m_retired = 0;
        end else begin
            exp_cv   = m_started && !m_wait_ack && !m_flush_now;
            exp_ret  = exp_cv && commit_ready;
            writes   = exp_ret && !commit_info[0] && !commit_mret_op;
            exp_rf   = writes && commit_rd_need && (commit_rd_idx != 0);
            exp_csr  = writes && commit_csr_need;
            exp_trap = exp_ret && commit_info[0];
            exp_mepc = commit_next_pc - 32'd4;

            check("commit_valid", commit_valid, exp_cv);
            check("flush", flush, m_flush_now);
            check("redirect_valid", redirect_valid, m_flush_now);
            if (m_flush_now) check("redirect_pc", redirect_pc, m_target);
            check("icache_inv_req", icache_inv_req, m_wait_ack);
            check("rf_wen", rf_wen, exp_rf);
            if (exp_rf) begin
                check("rf_waddr", rf_waddr, commit_rd_idx);
                check("rf_wdata", rf_wdata, commit_rd_data);
            end
            check("csr_wen", csr_wen, exp_csr);
            if (exp_csr) begin
                check("csr_waddr", csr_waddr, commit_csr_idx);
                check("csr_wdata", csr_wdata, commit_csr_data);
            end
            check("trap_wen", trap_wen, exp_trap);
            if (exp_trap) begin
                check("trap_mepc", trap_mepc, exp_mepc);
                check("trap_mcause", trap_mcause, commit_info[4:1]);
            end
`ifdef HICORE_COMMIT_RETIRE_CNT_EN
            check("minstret", minstret, m_retired);
`endif
            // advance model to the next cycle
            if (exp_ret && !commit_info[0]) m_retired = m_retired + 64'd1;
            if (m_flush_now) begin
                m_flush_now = 0;
            end else if (m_wait_ack) begin
                if (icache_inv_ack) begin
                    m_wait_ack  = 0;
                    m_flush_now = 1;
                end
            end else if (exp_ret) begin
                if (commit_info[0]) begin
                    m_target = mtvec; m_flush_now = 1;
                end else if (commit_mret_op) begin
                    m_target = mepc; m_flush_now = 1;
                end else if (commit_fence_i_op) begin
                    m_target = commit_next_pc; m_wait_ack = 1;
                end else if (commit_info[5]) begin
                    m_target = commit_next_pc; m_flush_now = 1;
                end
            end
            m_started = 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic head_idle();
        commit_ready = 1'b0; commit_rd_need = 1'b0; commit_rd_idx = '0; commit_rd_data = '0;
        commit_csr_need = 1'b0; commit_csr_idx = '0; commit_csr_data = '0;
        commit_fence_i_op = 1'b0; commit_mret_op = 1'b0; commit_next_pc = '0;
        commit_info = '0; icache_inv_ack = 1'b0;
    endtask

    task automatic head_random();
        commit_ready      = ($urandom_range(0, 3) != 0);
        commit_rd_need    = $urandom_range(0, 1) == 1;
        commit_rd_idx     = ($urandom_range(0, 3) == 0) ? 5'd0 : RFIDX_WIDTH'($urandom);
        commit_rd_data    = $urandom;
        commit_csr_need   = ($urandom_range(0, 3) == 0);
        commit_csr_idx    = CSRIDX_WIDTH'($urandom);
        commit_csr_data   = $urandom;
        commit_fence_i_op = ($urandom_range(0, 15) == 0);
        commit_mret_op    = ($urandom_range(0, 15) == 0);
        commit_next_pc    = $urandom;
        commit_info       = WB_SIZE'($urandom) & 8'hDE;
        commit_info[0]    = ($urandom_range(0, 11) == 0);
        commit_info[5]    = ($urandom_range(0, 9) == 0);
        mtvec             = $urandom;
        mepc              = $urandom;
        icache_inv_ack    = ($urandom_range(0, 3) == 0);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        head_idle();
        mtvec = 32'h80; mepc = 32'h0;
        step(); step();
        rst_n = 1'b1;
        // first cycle after release: registered commit_valid still 0; one edge later it is 1
        check("cv_before_first_edge", commit_valid, 0);
        step();
        check("cv_after_first_edge", commit_valid, 1);

        // normal retire, rd=5
        head_idle(); commit_ready = 1; commit_rd_need = 1; commit_rd_idx = 5;
        commit_rd_data = 32'hDEADBEEF; commit_next_pc = 32'h4;
        #1;
        check("tp_normal_rf_wen", rf_wen, 1);
        check("tp_normal_rf_wdata", rf_wdata, 32'hDEADBEEF);
        step();
        commit_rd_idx = 0;
        #1;
        check("tp_rd0_no_write", rf_wen, 0);
        step();

        // exception (with mret also set: trap path wins)
        head_idle(); commit_ready = 1; commit_rd_need = 1; commit_rd_idx = 7;
        commit_info = 8'b0000_0101; commit_mret_op = 1; commit_next_pc = 32'h104;
        mtvec = 32'h80; mepc = 32'h5550;
        #1;
        check("tp_exc_trap_wen", trap_wen, 1);
        check("tp_exc_mepc", trap_mepc, 32'h100);
        check("tp_exc_mcause", trap_mcause, 2);
        check("tp_exc_no_rf", rf_wen, 0);
        step();
        head_idle(); commit_ready = 1;
        #1;
        check("tp_exc_flush", flush, 1);
        check("tp_exc_redirect", redirect_pc, 32'h80);
        step();
        check("tp_exc_resume", commit_valid, 1);

        // mispredict with rd write
        head_idle(); commit_ready = 1; commit_rd_need = 1; commit_rd_idx = 3;
        commit_rd_data = 32'h1234; commit_info = 8'h20; commit_next_pc = 32'h2000;
        #1;
        check("tp_misp_rf_wen", rf_wen, 1);
        step();
        head_idle();
        #1;
        check("tp_misp_redirect", redirect_pc, 32'h2000);
        step();

        // fence.i, ack on 4th request cycle
        head_idle(); commit_ready = 1; commit_fence_i_op = 1; commit_next_pc = 32'h3000;
        step();
        head_idle(); commit_ready = 1;
        for (int i = 0; i < 4; i++) begin
            icache_inv_ack = (i == 3);
            #1;
            check("tp_fence_req", icache_inv_req, 1);
            check("tp_fence_cv", commit_valid, 0);
            step();
        end
        icache_inv_ack = 0;
        #1;
        check("tp_fence_redirect", redirect_pc, 32'h3000);
        step();

        // reset in the middle of FENCE_WAIT
        head_idle(); commit_ready = 1; commit_fence_i_op = 1; commit_next_pc = 32'h4000;
        step();
        head_idle(); commit_ready = 1;
        step();
        check("fw_req_before_reset", icache_inv_req, 1);
        rst_n = 1'b0;
        #1;
        check("fw_reset_inv_req", icache_inv_req, 0);
        check("fw_reset_flush", flush, 0);
        check("fw_reset_redirect", redirect_valid, 0);
        step(); step();
        // release with normal traffic queued: 10 back-to-back retires
        head_idle(); commit_ready = 1; commit_rd_need = 1; commit_rd_idx = 9; commit_next_pc = 32'h10;
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            commit_rd_data = $urandom;
            step();
        end
`ifdef HICORE_COMMIT_RETIRE_CNT_EN
        check("minstret_10", minstret, 64'd10);
`endif

        // random traffic with occasional resets
        for (int n = 0; n < 4000; n++) begin
            head_random();
            if (n % 1500 == 1499) do_reset();
            else step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
